// File: rtl/miv_ram_ecc_scrubber_pkg.sv
`default_nettype none
// ============================================================================
// Module      : miv_ram_ecc_scrubber_pkg
// Description : Shared types and constants for the RAM ECC scrubber: the
//               scrub FSM state encoding, default geometry of the protected
//               RAM, and a helper that sizes the idle-interval counter.
// Revision    : 1.0 - initial release
// ============================================================================
package miv_ram_ecc_scrubber_pkg;

    localparam int C_ADDR_W   = 7;     // 128-entry RAM
    localparam int C_DATA_W   = 21;    // corrected data word
    localparam int C_INTERVAL = 1024;  // idle cycles between scrub reads
    localparam int C_CNT_W    = 8;     // saturating SB write-back counter

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // counting down the idle interval
        ST_REQ   = 2'd1,   // waiting for a free read slot
        ST_CHECK = 2'd2,   // read data and ECC flags are on ram_rd
        ST_WB    = 2'd3    // writing the corrected word back
    } scrub_state_e;

    // Width of a down-counter that must hold INTERVAL-1; never below 1 bit.
    function automatic int interval_cnt_width(input int interval);
        return (interval > 1) ? $clog2(interval) : 1;
    endfunction

endpackage : miv_ram_ecc_scrubber_pkg
`default_nettype wire

// File: rtl/miv_scrub_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : miv_scrub_arbiter
// Description : Combinational RAM port mux between the core and the scrubber,
//               plus gating of the RAM ECC flags so the core only sees flags
//               that belong to its own reads.
//   i_scrub_issue    scrub read is being issued this cycle (read port to ptr)
//   i_scrub_wb       scrub write-back is being performed this cycle
//   i_scrub_rd_q     ram_rd this cycle is the result of a scrub read
//   i_scrub_ptr      scrub address
//   i_scrub_wd       corrected word held by the scrubber
//   i_core_*         core functional port
//   i_ram_sb/db_*    RAM ECC flags aligned with ram_rd
//   o_ram_*          RAM read/write port
//   o_core_sb/db_*   ECC flags visible to the core
// Revision    : 1.0 - initial release
// ============================================================================
module miv_scrub_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 21
) (
    input  logic              i_scrub_issue,
    input  logic              i_scrub_wb,
    input  logic              i_scrub_rd_q,
    input  logic [ADDR_W-1:0] i_scrub_ptr,
    input  logic [DATA_W-1:0] i_scrub_wd,
    input  logic [ADDR_W-1:0] i_core_raddr,
    input  logic              i_core_wen,
    input  logic [ADDR_W-1:0] i_core_waddr,
    input  logic [DATA_W-1:0] i_core_wd,
    input  logic              i_ram_sb_correct,
    input  logic              i_ram_db_detect,
    output logic [ADDR_W-1:0] o_ram_raddr,
    output logic [ADDR_W-1:0] o_ram_waddr,
    output logic [DATA_W-1:0] o_ram_wd,
    output logic              o_ram_wen,
    output logic              o_core_sb_correct,
    output logic              o_core_db_detect
);

    // The scrubber only issues when the core is idle, so the core address is
    // the default and the scrub pointer overrides it for that single cycle.
    assign o_ram_raddr = i_scrub_issue ? i_scrub_ptr : i_core_raddr;

    // i_scrub_wb is only raised when the core is not writing, so the core
    // write always takes the port when present.
    assign o_ram_waddr = i_scrub_wb ? i_scrub_ptr : i_core_waddr;
    assign o_ram_wd    = i_scrub_wb ? i_scrub_wd  : i_core_wd;
    assign o_ram_wen   = i_scrub_wb | i_core_wen;

    assign o_core_sb_correct = i_ram_sb_correct & ~i_scrub_rd_q;
    assign o_core_db_detect  = i_ram_db_detect  & ~i_scrub_rd_q;

endmodule : miv_scrub_arbiter
`default_nettype wire

// File: rtl/miv_ram_ecc_scrubber.sv
`default_nettype none
// ============================================================================
// Module      : miv_ram_ecc_scrubber
// Description : Background scrubber for a single ECC two-port RAM. Owns the
//               RAM ports, gives the core absolute priority, and in idle
//               slots walks every address: single-bit-corrected words are
//               written back, the first uncorrectable address is captured.
//   CLK, RESET           clock, synchronous active-high reset
//   scrub_en             enables background scrubbing
//   core_*               core functional port (read, write, ECC flags)
//   ram_*                RAM read/write port and ECC flags
//   sb_count             saturating count of scrub write-backs
//   db_err, db_addr      sticky uncorrectable flag and its first address
//   db_clr               clears db_err / db_addr
//   pass_done            pulse when the scrub pointer wraps to 0
// Revision    : 1.0 - initial release
// ============================================================================
module miv_ram_ecc_scrubber
    import miv_ram_ecc_scrubber_pkg::*;
#(
    parameter int ADDR_W   = C_ADDR_W,
    parameter int DATA_W   = C_DATA_W,
    parameter int INTERVAL = C_INTERVAL,
    parameter int CNT_W    = C_CNT_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              scrub_en,
    input  logic              core_ren,
    input  logic [ADDR_W-1:0] core_raddr,
    input  logic              core_wen,
    input  logic [ADDR_W-1:0] core_waddr,
    input  logic [DATA_W-1:0] core_wd,
    output logic [DATA_W-1:0] core_rd,
    output logic              core_sb_correct,
    output logic              core_db_detect,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wd,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_rd,
    input  logic              ram_sb_correct,
    input  logic              ram_db_detect,
    output logic [CNT_W-1:0]  sb_count,
    output logic              db_err,
    output logic [ADDR_W-1:0] db_addr,
    input  logic              db_clr,
    output logic              pass_done
);

    localparam int                IW         = interval_cnt_width(INTERVAL);
    localparam logic [IW-1:0]     C_RELOAD   = IW'(INTERVAL - 1);
    localparam logic [ADDR_W-1:0] C_PTR_LAST = '1;
    localparam logic [CNT_W-1:0]  C_SB_MAX   = '1;

    scrub_state_e      state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [IW-1:0]     icnt_q, icnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              scrub_rd_q, scrub_rd_d;
    logic [CNT_W-1:0]  sb_count_q, sb_count_d;
    logic              db_err_q, db_err_d;
    logic [ADDR_W-1:0] db_addr_q, db_addr_d;
    logic              pass_done_q, pass_done_d;

    logic              w_issue;
    logic              w_wb_go;
    logic              w_advance;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        icnt_d      = icnt_q;
        data_d      = data_q;
        sb_count_d  = sb_count_q;
        db_err_d    = db_err_q;
        db_addr_d   = db_addr_q;
        pass_done_d = 1'b0;
        w_issue     = 1'b0;
        w_wb_go     = 1'b0;
        w_advance   = 1'b0;

        // A DB event in the same cycle overrides this below.
        if (db_clr) begin
            db_err_d  = 1'b0;
            db_addr_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!scrub_en) begin
                    icnt_d = C_RELOAD;
                end else if (icnt_q == '0) begin
                    icnt_d  = C_RELOAD;
                    state_d = ST_REQ;
                end else begin
                    icnt_d = icnt_q - IW'(1);
                end
            end
            ST_REQ: begin
                // Nothing is in flight yet, so disabling simply parks.
                if (!scrub_en) begin
                    state_d = ST_IDLE;
                end else if (!core_ren && !core_wen) begin
                    // A write here would zero the flags of our read result.
                    w_issue = 1'b1;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                data_d = ram_rd;
                if (core_wen && (core_waddr == ptr_q)) begin
                    // The core is overwriting the word we just read.
                    w_advance = 1'b1;
                end else if (ram_db_detect) begin
                    if (!db_err_q || db_clr) begin
                        db_err_d  = 1'b1;
                        db_addr_d = ptr_q;
                    end
                    w_advance = 1'b1;
                end else if (ram_sb_correct) begin
                    state_d = ST_WB;
                end else begin
                    w_advance = 1'b1;
                end
            end
            ST_WB: begin
                if (core_wen) begin
                    // Same address: core data is newer, drop ours.
                    // Other address: the write port is busy, retry.
                    if (core_waddr == ptr_q) begin
                        w_advance = 1'b1;
                    end
                end else if (!RESET) begin
                    w_wb_go = 1'b1;
                    if (sb_count_q != C_SB_MAX) begin
                        sb_count_d = sb_count_q + CNT_W'(1);
                    end
                    w_advance = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_advance) begin
            ptr_d       = ptr_q + ADDR_W'(1);
            pass_done_d = (ptr_q == C_PTR_LAST);
            state_d     = ST_IDLE;
        end

        scrub_rd_d = w_issue;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            icnt_q      <= C_RELOAD;
            data_q      <= '0;
            scrub_rd_q  <= 1'b0;
            sb_count_q  <= '0;
            db_err_q    <= 1'b0;
            db_addr_q   <= '0;
            pass_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            icnt_q      <= icnt_d;
            data_q      <= data_d;
            scrub_rd_q  <= scrub_rd_d;
            sb_count_q  <= sb_count_d;
            db_err_q    <= db_err_d;
            db_addr_q   <= db_addr_d;
            pass_done_q <= pass_done_d;
        end
    end

    miv_scrub_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_arbiter (
        .i_scrub_issue     (w_issue),
        .i_scrub_wb        (w_wb_go),
        .i_scrub_rd_q      (scrub_rd_q),
        .i_scrub_ptr       (ptr_q),
        .i_scrub_wd        (data_q),
        .i_core_raddr      (core_raddr),
        .i_core_wen        (core_wen),
        .i_core_waddr      (core_waddr),
        .i_core_wd         (core_wd),
        .i_ram_sb_correct  (ram_sb_correct),
        .i_ram_db_detect   (ram_db_detect),
        .o_ram_raddr       (ram_raddr),
        .o_ram_waddr       (ram_waddr),
        .o_ram_wd          (ram_wd),
        .o_ram_wen         (ram_wen),
        .o_core_sb_correct (core_sb_correct),
        .o_core_db_detect  (core_db_detect)
    );

    assign core_rd   = ram_rd;
    assign sb_count  = sb_count_q;
    assign db_err    = db_err_q;
    assign db_addr   = db_addr_q;
    assign pass_done = pass_done_q;

endmodule : miv_ram_ecc_scrubber
`default_nettype wire

// File: tb/tb_miv_ram_ecc_scrubber.sv
`default_nettype none
// ============================================================================
// Module      : tb_miv_ram_ecc_scrubber
// Description : Self-checking bench for miv_ram_ecc_scrubber with a
//               behavioural ECC RAM model; full-pass scenarios from a vector
//               table plus directed multi-cycle corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_miv_ram_ecc_scrubber;

    localparam int AW = 7;
    localparam int DW = 21;
    localparam int CW = 8;
    localparam int NV = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          scrub_en = 1'b1;
    logic          core_ren = 1'b0;
    logic [AW-1:0] core_raddr = '0;
    logic          core_wen = 1'b0;
    logic [AW-1:0] core_waddr = '0;
    logic [DW-1:0] core_wd = '0;
    logic          db_clr = 1'b0;
    logic [DW-1:0] core_rd;
    logic          core_sb_correct, core_db_detect;
    logic [AW-1:0] ram_raddr, ram_waddr;
    logic [DW-1:0] ram_wd;
    logic          ram_wen;
    logic [DW-1:0] ram_rd;
    logic          ram_sb_correct, ram_db_detect;
    logic [CW-1:0] sb_count;
    logic          db_err;
    logic [AW-1:0] db_addr;
    logic          pass_done;

    always #5 CLK = ~CLK;

    miv_ram_ecc_scrubber #(
        .ADDR_W(AW), .DATA_W(DW), .INTERVAL(4), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .RESET(RESET), .scrub_en(scrub_en),
        .core_ren(core_ren), .core_raddr(core_raddr),
        .core_wen(core_wen), .core_waddr(core_waddr), .core_wd(core_wd),
        .core_rd(core_rd), .core_sb_correct(core_sb_correct),
        .core_db_detect(core_db_detect),
        .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wd(ram_wd),
        .ram_wen(ram_wen), .ram_rd(ram_rd), .ram_sb_correct(ram_sb_correct),
        .ram_db_detect(ram_db_detect),
        .sb_count(sb_count), .db_err(db_err), .db_addr(db_addr),
        .db_clr(db_clr), .pass_done(pass_done)
    );

    // ---------------- RAM model ----------------
    logic [DW-1:0] cfg_data [128];
    bit            cfg_sb   [128];
    bit            cfg_db   [128];
    bit            load = 1'b0;
    logic [DW-1:0] mem  [128];
    bit            sb_f [128];
    bit            db_f [128];

    always @(posedge CLK) begin
        if (load) begin
            for (int i = 0; i < 128; i++) begin
                mem[i]  <= cfg_data[i];
                sb_f[i] <= cfg_sb[i];
                db_f[i] <= cfg_db[i];
            end
            ram_rd         <= '0;
            ram_sb_correct <= 1'b0;
            ram_db_detect  <= 1'b0;
        end else begin
            ram_rd         <= mem[ram_raddr];
            ram_sb_correct <= !ram_wen && sb_f[ram_raddr];
            ram_db_detect  <= !ram_wen && db_f[ram_raddr];
            if (ram_wen) begin
                mem[ram_waddr]  <= ram_wd;
                sb_f[ram_waddr] <= 1'b0;
                db_f[ram_waddr] <= 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    bit            mon_clr = 1'b0;
    int            wr_cnt, pass_cnt, csb_cnt, cdb_cnt;
    logic [AW-1:0] last_wa;
    logic [DW-1:0] last_wd;
    logic [127:0]  seen;

    always @(negedge CLK) begin
        if (mon_clr) begin
            wr_cnt <= 0; pass_cnt <= 0; csb_cnt <= 0; cdb_cnt <= 0;
            last_wa <= '0; last_wd <= '0; seen <= '0;
        end else begin
            if (ram_wen) begin
                wr_cnt  <= wr_cnt + 1;
                last_wa <= ram_waddr;
                last_wd <= ram_wd;
            end
            if (pass_done)       pass_cnt <= pass_cnt + 1;
            if (core_sb_correct) csb_cnt  <= csb_cnt + 1;
            if (core_db_detect)  cdb_cnt  <= cdb_cnt + 1;
            seen[ram_raddr] <= 1'b1;
        end
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cfg_default();
        for (int i = 0; i < 128; i++) begin
            cfg_data[i] = DW'(32'h0A000 + i);
            cfg_sb[i]   = 1'b0;
            cfg_db[i]   = 1'b0;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1; load = 1'b1; mon_clr = 1'b1;
        core_wen = 1'b0; db_clr = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0; load = 1'b0; mon_clr = 1'b0;
    endtask

    task automatic wait_pass(input int budget, input string name);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge CLK);
            if (pass_done) got = 1'b1;
        end
        #1;
        chk(name, {31'b0, got}, 32'd1);
    endtask

    task automatic wait_sb(input int budget, input string name);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge CLK);
            if (ram_sb_correct) got = 1'b1;
        end
        chk(name, {31'b0, got}, 32'd1);
    endtask

    typedef struct {
        logic [7:0]    sb0;      // 8'hFF = none
        logic [DW-1:0] d0;       // stored (corrected) data at sb0
        logic [7:0]    sb1;
        logic [7:0]    db0;
        logic [7:0]    db1;
        int            exp_wr;
        int            exp_sbc;
        bit            exp_dbe;
        logic [AW-1:0] exp_dba;
        logic [AW-1:0] exp_wa;
        logic [DW-1:0] exp_wd;
    } vec_t;

    vec_t vt [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int mis;
        vt[0] = '{sb0:8'hFF, d0:21'h0, sb1:8'hFF, db0:8'hFF, db1:8'hFF,
                  exp_wr:0, exp_sbc:0, exp_dbe:1'b0, exp_dba:7'h00, exp_wa:7'h00, exp_wd:21'h0};
        vt[1] = '{sb0:8'h05, d0:21'h1ABCD, sb1:8'hFF, db0:8'hFF, db1:8'hFF,
                  exp_wr:1, exp_sbc:1, exp_dbe:1'b0, exp_dba:7'h00, exp_wa:7'h05, exp_wd:21'h1ABCD};
        vt[2] = '{sb0:8'hFF, d0:21'h0, sb1:8'hFF, db0:8'h10, db1:8'h20,
                  exp_wr:0, exp_sbc:0, exp_dbe:1'b1, exp_dba:7'h10, exp_wa:7'h00, exp_wd:21'h0};
        vt[3] = '{sb0:8'h05, d0:21'h0A005, sb1:8'h7F, db0:8'hFF, db1:8'hFF,
                  exp_wr:2, exp_sbc:2, exp_dbe:1'b0, exp_dba:7'h00, exp_wa:7'h7F, exp_wd:21'h0A07F};

        // ---- reset state ----
        cfg_default();
        do_reset();
        @(negedge CLK); #1;
        chk("rst_sb_count", 32'(sb_count), 0);
        chk("rst_db_err", 32'(db_err), 0);
        chk("rst_db_addr", 32'(db_addr), 0);
        chk("rst_pass_done", 32'(pass_done), 0);
        chk("rst_ram_wen", 32'(ram_wen), 0);

        // ---- full-pass vector table ----
        for (int v = 0; v < NV; v++) begin
            cfg_default();
            if (vt[v].sb0 != 8'hFF) begin
                cfg_sb[vt[v].sb0[6:0]]   = 1'b1;
                cfg_data[vt[v].sb0[6:0]] = vt[v].d0;
            end
            if (vt[v].sb1 != 8'hFF) cfg_sb[vt[v].sb1[6:0]] = 1'b1;
            if (vt[v].db0 != 8'hFF) cfg_db[vt[v].db0[6:0]] = 1'b1;
            if (vt[v].db1 != 8'hFF) cfg_db[vt[v].db1[6:0]] = 1'b1;
            core_raddr = '0;
            do_reset();
            wait_pass(1000, $sformatf("v%0d_pass_done", v));
            chk($sformatf("v%0d_pass_cnt", v), 32'(pass_cnt), 1);
            chk($sformatf("v%0d_addrs_read", v), 32'($countones(seen)), 128);
            chk($sformatf("v%0d_writes", v), 32'(wr_cnt), 32'(vt[v].exp_wr));
            chk($sformatf("v%0d_sb_count", v), 32'(sb_count), 32'(vt[v].exp_sbc));
            chk($sformatf("v%0d_db_err", v), 32'(db_err), 32'(vt[v].exp_dbe));
            chk($sformatf("v%0d_db_addr", v), 32'(db_addr), 32'(vt[v].exp_dba));
            chk($sformatf("v%0d_core_sb", v), 32'(csb_cnt), 0);
            chk($sformatf("v%0d_core_db", v), 32'(cdb_cnt), 0);
            if (vt[v].exp_wr > 0) begin
                chk($sformatf("v%0d_last_waddr", v), 32'(last_wa), 32'(vt[v].exp_wa));
                chk($sformatf("v%0d_last_wd", v), 32'(last_wd), 32'(vt[v].exp_wd));
            end
        end

        // ---- db_clr then re-hit of the second DB address ----
        cfg_default();
        cfg_db[7'h10] = 1'b1;
        cfg_db[7'h20] = 1'b1;
        do_reset();
        wait_pass(1000, "dbclr_pass1");
        chk("dbclr_first_addr", 32'(db_addr), 32'h10);
        @(posedge CLK); #1;
        core_wen = 1'b1; core_waddr = 7'h10; core_wd = 21'h0A010; db_clr = 1'b1;
        @(posedge CLK); #1;
        core_wen = 1'b0; db_clr = 1'b0;
        @(negedge CLK);
        chk("dbclr_err_cleared", 32'(db_err), 0);
        chk("dbclr_addr_cleared", 32'(db_addr), 0);
        wait_pass(1000, "dbclr_pass2");
        chk("dbclr_err_again", 32'(db_err), 1);
        chk("dbclr_second_addr", 32'(db_addr), 32'h20);

        // ---- core read priority while the scrubber waits in REQ ----
        cfg_default();
        cfg_sb[7'h55] = 1'b1;
        core_raddr = 7'h55;
        core_ren   = 1'b1;
        do_reset();
        mis = 0;
        for (int i = 0; i < 54; i++) begin
            @(negedge CLK);
            if (ram_raddr != 7'h55) mis++;
        end
        chk("prio_no_scrub_read", 32'(mis), 0);
        chk("prio_core_rd", 32'(core_rd), 32'h0A055);
        chk("prio_core_sb_pass", 32'(core_sb_correct), 1);
        @(posedge CLK); #1;
        core_ren = 1'b0;
        @(negedge CLK);
        chk("prio_first_idle_ptr", 32'(ram_raddr), 0);
        @(negedge CLK);
        chk("prio_back_to_core", 32'(ram_raddr), 32'h55);

        // ---- write race: core writes the scrub address during WB ----
        cfg_default();
        cfg_sb[7'h07] = 1'b1;
        core_raddr = '0;
        do_reset();
        wait_sb(200, "race_same_sb_seen");
        @(posedge CLK); #1;
        core_wen = 1'b1; core_waddr = 7'h07; core_wd = 21'h0BEEF;
        @(negedge CLK);
        chk("race_same_core_waddr", 32'(ram_waddr), 32'h07);
        chk("race_same_core_wd", 32'(ram_wd), 32'h0BEEF);
        @(posedge CLK); #1;
        core_wen = 1'b0;
        @(negedge CLK);
        chk("race_same_wb_cancel", 32'(ram_wen), 0);
        repeat (3) @(negedge CLK);
        chk("race_same_sb_count", 32'(sb_count), 0);
        chk("race_same_mem", 32'(mem[7'h07]), 32'h0BEEF);
        chk("race_same_writes", 32'(wr_cnt), 1);

        // ---- write race: core writes another address during WB ----
        cfg_default();
        cfg_sb[7'h07] = 1'b1;
        do_reset();
        wait_sb(200, "race_other_sb_seen");
        @(posedge CLK); #1;
        core_wen = 1'b1; core_waddr = 7'h08; core_wd = 21'h01234;
        @(negedge CLK);
        chk("race_other_core_waddr", 32'(ram_waddr), 32'h08);
        chk("race_other_core_wd", 32'(ram_wd), 32'h01234);
        @(posedge CLK); #1;
        core_wen = 1'b0;
        @(negedge CLK);
        chk("race_other_wb_wen", 32'(ram_wen), 1);
        chk("race_other_wb_waddr", 32'(ram_waddr), 32'h07);
        chk("race_other_wb_wd", 32'(ram_wd), 32'h0A007);
        @(negedge CLK);
        chk("race_other_sb_count", 32'(sb_count), 1);
        chk("race_other_mem8", 32'(mem[7'h08]), 32'h01234);

        // ---- reset asserted in the WB cycle ----
        cfg_default();
        cfg_sb[7'h05] = 1'b1;
        core_raddr = 7'h33;
        do_reset();
        wait_sb(200, "rstwb_sb_seen");
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("rstwb_ram_wen", 32'(ram_wen), 0);
        chk("rstwb_sb_count", 32'(sb_count), 0);
        chk("rstwb_no_write", 32'(wr_cnt), 0);
        begin
            bit got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge CLK);
                if (ram_raddr != 7'h33) got = 1'b1;
            end
            chk("rstwb_scrub_seen", {31'b0, got}, 1);
            chk("rstwb_ptr_zero", 32'(ram_raddr), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_miv_ram_ecc_scrubber
`default_nettype wire
